gray_burst_sched: RTL and testbench
===================================

Name: gray_burst_sched

Overview:
Round-robin scheduler that shares one Gray-code counter datapath between NREQ requesters.
Each requester asks for a burst of `len` Gray codes. The block arbitrates, grants one requester, and sequences the counter from 0 to len-1, presenting the Gray-encoded values. It then signals completion and re-arbitrates.
It sits between client blocks and the Gray counter resource, which is built into this block's datapath.

Parameters:
- NREQ, 4: number of requesters (2..16).
- CBITS, 8: counter and length width in bits.
- IDW, $clog2(NREQ): derived, owner index width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- req  input  NREQ  per-requester request, level.
- len  input  NREQ*CBITS  flattened burst lengths; requester i owns bits [i*CBITS +: CBITS].
- grant  output  NREQ  one-hot grant, held for the whole burst.
- owner  output  IDW  index of the granted requester; valid while busy.
- busy  output  1  burst in progress.
- gray_o  output  CBITS  Gray code of the internal binary count: bin ^ (bin >> 1).
- valid_o  output  1  gray_o is a valid burst beat this cycle.
- done  output  1  one-cycle pulse on the final cycle of a burst.

Behaviour:
- Reset, sampled on clk while rst==0:
  - grant=0, owner=0, busy=0, gray_o=0, valid_o=0, done=0.
  - Internal bin=0, state=IDLE, last-owner pointer=NREQ-1, so requester 0 has first priority.
- All outputs are registered.
- States: IDLE, RUN, ZERO.
- IDLE:
  - No req bit set: stay in IDLE, all outputs 0.
  - Otherwise pick the first set req at index last+1, last+2, ... (mod NREQ). That is the winner w.
  - Next cycle: grant=onehot(w), owner=w, busy=1, last=w, and len[w] is latched into len_q.
  - len[w]!=0: go to RUN with bin=0, valid_o=1, gray_o=0.
  - len[w]==0: go to ZERO.
- RUN:
  - Each cycle valid_o=1 and gray_o=gray(bin).
  - bin==len_q-1: done=1 on this same cycle; next cycle go to IDLE with grant=0, busy=0, valid_o=0, bin=0.
  - Otherwise bin increments by 1. bin never exceeds len_q-1, so there is no wrap (maximum burst is 2^CBITS-1 beats).
- ZERO: a single cycle with grant/busy=1, done=1, valid_o=0. Next cycle go to IDLE.
- Latency:
  - req seen in IDLE at cycle t gives grant and the first beat at t+1.
  - A burst of length L occupies cycles t+1..t+L.
  - The earliest next grant is at t+L+2: one mandatory IDLE bubble between bursts.
- req is sampled only in IDLE.
  - Deasserting req during a burst has no effect; the burst completes.
  - Changing len during a burst has no effect, because len_q is latched.
- Successive valid beats within a burst differ in exactly one bit of gray_o.
- Fairness: a requester holding req continuously is granted within NREQ bursts.
- Reset mid-burst aborts immediately. The next cycle shows reset values and the priority pointer returns to NREQ-1.
- Invariants:
  - grant is one-hot or zero.
  - busy == |grant.
  - valid_o implies busy.
  - done implies busy.

Decomposition:
- Package gray_sched_pkg holds:
  - state enum {IDLE, RUN, ZERO};
  - function bin2gray(logic [CBITS-1:0]);
  - function rr_pick(req, last) returning the winner index.
- One natural sub-module: rr_arbiter (NREQ), combinational winner select plus the last-owner pointer register.
- Counter, length latch and FSM stay in the top module.

Test Plan:
- Reset then single requester: rst=0 for 2 cycles, then req=4'b0001, len[0]=5.
  - grant=0001 at t+1..t+5.
  - gray_o = 0, 1, 3, 2, 6.
  - done at t+5; grant=0 at t+6.
- Round-robin with all requesting: req=4'b1111, all len=2, held.
  - Owners in order 0, 1, 2, 3, 0.
  - One IDLE cycle between bursts.
  - Each burst gray_o = 0, 1.
- Zero length: req=4'b0100, len[2]=0.
  - One cycle with grant=0100, done=1, valid_o=0.
  - IDLE next cycle.
- Mid-burst req drop and len change: req[1] with len=4.
  - Drop req and set len=9 at beat 2.
  - Exactly 4 beats (0, 1, 3, 2) are still produced, then done.
- Reset mid-burst: len=200 burst, rst=0 at beat 50.
  - Next cycle all outputs 0.
  - After release with req=4'b1000, requester 3 wins at t+1, because the pointer reset makes requester 0 first priority and no lower index requests.
- Max length: len=255.
  - 255 beats.
  - Last gray_o = gray(254) = 8'h81.
  - Every consecutive pair of beats has a Hamming distance of 1.
  - done only on the last beat.

Source files
------------

// File: rtl/gray_sched_pkg.sv
// Purpose : shared types and helpers for the Gray-code burst scheduler.
// Latency : n/a (package: state enum, Gray encoder, round-robin pick).
// Backpressure: n/a.
//
// Helpers work on the widest supported widths (16 requesters, 32-bit
// counters); callers size-cast their arguments in and results out.
package gray_sched_pkg;

   localparam int MAX_NREQ  = 16;
   localparam int MAX_CBITS = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      ZERO = 2'd2
   } state_t;

   // Binary to reflected Gray code.
   function automatic logic [MAX_CBITS-1:0] bin2gray(input logic [MAX_CBITS-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Round-robin winner: first set request at last+1, last+2, ... (mod nreq).
   // Returns 'last' unchanged when nothing is requesting; callers only use
   // the result when at least one request bit is set.
   function automatic logic [3:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                          input logic [3:0]          last,
                                          input int                  nreq);
      logic [3:0] win;
      logic       found;
      int         idx;
      win   = last;
      found = 1'b0;
      for (int k = 1; k <= MAX_NREQ; k++) begin
         idx = (int'(last) + k) % nreq;
         if (!found && (k <= nreq) && req[idx[3:0]]) begin
            win   = idx[3:0];
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/gray_burst_sched_rr_arbiter.sv
// Purpose : round-robin winner select plus the last-owner pointer register.
// Latency : winner is combinational from req; pointer updates on the clock after take.
// Backpressure: none; the pointer only moves when the caller asserts take.
//
// Ports:
//   clk, rst   clock and synchronous active-low reset (pointer -> NREQ-1)
//   req        per-requester request bits
//   take       load the current winner into the last-owner pointer
//   winner     index of the next requester in round-robin order
//   any        at least one request bit is set
module rr_arbiter
   import gray_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            take,
   output logic [IDW-1:0]  winner,
   output logic            any
);

   logic [IDW-1:0] last;

   always_comb begin
      winner = IDW'(rr_pick(MAX_NREQ'(req), 4'(last), NREQ));
      any    = |req;
   end

   // Resetting to NREQ-1 makes requester 0 the first in line.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last <= IDW'(NREQ - 1);
      end else if (take) begin
         last <= winner;
      end
   end

endmodule

// File: rtl/gray_burst_sched.sv
// Purpose : round-robin scheduler sharing one Gray-code counter among NREQ requesters.
// Latency : request seen in IDLE at t -> grant and first beat at t+1; burst of L
//           beats occupies t+1..t+L; one IDLE bubble before the next grant.
// Backpressure: none; req is only sampled in IDLE and held requests simply wait.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-low reset
//   req      per-requester level request
//   len      flattened burst lengths, requester i owns [i*CBITS +: CBITS]
//   grant    one-hot grant held for the whole burst
//   owner    granted requester index (valid while busy)
//   busy     burst in progress
//   gray_o   Gray code of the internal binary count
//   valid_o  gray_o carries a burst beat this cycle
//   done     pulse on the final cycle of a burst (including zero-length)
module gray_burst_sched
   import gray_sched_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int CBITS = 8,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*CBITS-1:0] len,
   output logic [NREQ-1:0]       grant,
   output logic [IDW-1:0]        owner,
   output logic                  busy,
   output logic [CBITS-1:0]      gray_o,
   output logic                  valid_o,
   output logic                  done
);

   if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
      $error("gray_burst_sched: NREQ must be in 2..16");
   end
   if (CBITS < 1 || CBITS > MAX_CBITS) begin : g_bad_cbits
      $error("gray_burst_sched: CBITS must be in 1..32");
   end

   state_t           state, state_d;
   logic [CBITS-1:0] bin, bin_d;
   logic [CBITS-1:0] len_q, len_d;
   logic [CBITS-1:0] last_beat;
   logic [CBITS-1:0] win_len;

   logic [NREQ-1:0]  grant_d;
   logic [IDW-1:0]   owner_d;
   logic             busy_d;
   logic [CBITS-1:0] gray_d;
   logic             valid_d;
   logic             done_d;

   logic [IDW-1:0]   winner;
   logic             any_req;
   logic             take;

   // Arbitration only happens from IDLE; the pointer advances with each grant.
   assign take = (state == IDLE) && any_req;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .take   (take),
      .winner (winner),
      .any    (any_req)
   );

   // Length of the current winner, selected from the flattened bus.
   always_comb begin
      win_len = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (winner == IDW'(i)) begin
            win_len = len[i*CBITS +: CBITS];
         end
      end
   end

   // len_q is never zero in RUN, so len_q-1 is the index of the final beat.
   assign last_beat = len_q - CBITS'(1);

   // Next-state and next-output logic.  Every output is registered, so the
   // values computed here are what the outputs show on the following cycle;
   // done is therefore predicted one cycle ahead from the beat that will be
   // presented next.
   always_comb begin
      state_d = state;
      bin_d   = bin;
      len_d   = len_q;
      grant_d = '0;
      owner_d = '0;
      busy_d  = 1'b0;
      gray_d  = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;

      case (state)
         IDLE: begin
            if (any_req) begin
               grant_d = NREQ'(1) << winner;
               owner_d = winner;
               busy_d  = 1'b1;
               len_d   = win_len;
               bin_d   = '0;
               if (win_len != '0) begin
                  state_d = RUN;
                  valid_d = 1'b1;
                  gray_d  = '0;
                  done_d  = (win_len == CBITS'(1));
               end else begin
                  state_d = ZERO;
                  done_d  = 1'b1;
               end
            end
         end

         RUN: begin
            if (bin == last_beat) begin
               // Final beat is on the outputs now; drop to the IDLE bubble.
               state_d = IDLE;
               bin_d   = '0;
            end else begin
               state_d = RUN;
               bin_d   = bin + CBITS'(1);
               grant_d = grant;
               owner_d = owner;
               busy_d  = 1'b1;
               valid_d = 1'b1;
               gray_d  = CBITS'(bin2gray(MAX_CBITS'(bin_d)));
               done_d  = (bin_d == last_beat);
            end
         end

         ZERO: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         bin     <= '0;
         len_q   <= '0;
         grant   <= '0;
         owner   <= '0;
         busy    <= 1'b0;
         gray_o  <= '0;
         valid_o <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_d;
         bin     <= bin_d;
         len_q   <= len_d;
         grant   <= grant_d;
         owner   <= owner_d;
         busy    <= busy_d;
         gray_o  <= gray_d;
         valid_o <= valid_d;
         done    <= done_d;
      end
   end

endmodule

// File: tb/tb_gray_burst_sched.sv
module tb_gray_burst_sched;

   localparam int NREQ  = 4;
   localparam int CBITS = 8;
   localparam int IDW   = 2;
   localparam int LW    = NREQ * CBITS;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [NREQ-1:0]      req = '0;
   logic [LW-1:0]        len = '0;
   logic [NREQ-1:0]      grant;
   logic [IDW-1:0]       owner;
   logic                 busy;
   logic [CBITS-1:0]     gray_o;
   logic                 valid_o;
   logic                 done;

   gray_burst_sched #(
      .NREQ  (NREQ),
      .CBITS (CBITS),
      .IDW   (IDW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .len     (len),
      .grant   (grant),
      .owner   (owner),
      .busy    (busy),
      .gray_o  (gray_o),
      .valid_o (valid_o),
      .done    (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NREQ-1:0]  g;
      logic [IDW-1:0]   o;
      logic             b;
      logic [CBITS-1:0] gr;
      logic             v;
      logic             d;
   } exp_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];
   exp_t exp_o;
   int   m_last = NREQ - 1;

   function automatic exp_t act_vec();
      exp_t a;
      a.g  = grant;
      a.o  = owner;
      a.b  = busy;
      a.gr = gray_o;
      a.v  = valid_o;
      a.d  = done;
      return a;
   endfunction

   function automatic logic [LW-1:0] with_len(input logic [LW-1:0] cur, input int i, input int v);
      logic [LW-1:0] m, x;
      m = LW'((1 << CBITS) - 1) << (i * CBITS);
      x = LW'(v & ((1 << CBITS) - 1)) << (i * CBITS);
      return (cur & ~m) | x;
   endfunction

   // Transaction-level reference: when idle and some request is up, the
   // whole burst (beats + trailing idle bubble) is queued at once; each clock
   // pops the expected output of the cycle that follows that edge.
   task automatic tick();
      int            w, idx, l;
      logic [LW-1:0] lw;
      exp_t          e;
      @(posedge clk);
      if (!rst) begin
         q.delete();
         m_last = NREQ - 1;
         exp_o  = '0;
      end else if (q.size() != 0) begin
         exp_o = q.pop_front();
      end else if (req == '0) begin
         exp_o = '0;
      end else begin
         w = -1;
         for (int k = 1; k <= NREQ; k++) begin
            idx = (m_last + k) % NREQ;
            if (w < 0 && req[idx[IDW-1:0]]) w = idx;
         end
         m_last = w;
         lw = len >> (w * CBITS);
         l  = int'(lw[CBITS-1:0]);
         e   = '0;
         e.g = NREQ'(1) << w;
         e.o = IDW'(w);
         e.b = 1'b1;
         if (l == 0) begin
            e.d = 1'b1;
            q.push_back(e);
         end else begin
            for (int i = 0; i < l; i++) begin
               e.gr = CBITS'(i ^ (i >> 1));
               e.v  = 1'b1;
               e.d  = (i == l - 1);
               q.push_back(e);
            end
         end
         q.push_back('0);
         exp_o = q.pop_front();
      end
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 600 && q.size() != 0; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req = '1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if (act_vec() !== '0) begin
            n_bad++;
            $display("FAIL reset cyc %0d: got %h expected 0", i, act_vec());
         end
      end
      req = '0;
      rst = 1'b1;
   endtask

   task automatic test_single();
      logic [CBITS-1:0] g[5] = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06};
      req = 4'b0001;
      len = with_len(len, 0, 5);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 0) req = '0;
         n_cmp++;
         if (act_vec() !== exp_o) begin
            n_bad++;
            $display("FAIL single model cyc %0d: got %h expected %h", i, act_vec(), exp_o);
         end
         n_cmp++;
         if (i < 5) begin
            if (grant !== 4'b0001 || gray_o !== g[i] || valid_o !== 1'b1 || done !== (i == 4)) begin
               n_bad++;
               $display("FAIL single beat %0d: grant=%b gray=%h done=%b, expected grant=0001 gray=%h done=%b",
                        i, grant, gray_o, done, g[i], (i == 4));
            end
         end else if (grant !== '0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single end: grant=%b busy=%b expected 0", grant, busy);
         end
      end
      drain();
   endtask

   task automatic test_round_robin();
      int b, ph;
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < NREQ; i++) len = with_len(len, i, 2);
      for (int c = 0; c < 15; c++) begin
         tick();
         b  = c / 3;
         ph = c % 3;
         n_cmp++;
         if (act_vec() !== exp_o) begin
            n_bad++;
            $display("FAIL rr model cyc %0d: got %h expected %h", c, act_vec(), exp_o);
         end
         n_cmp++;
         if (ph < 2) begin
            if (owner !== IDW'(b % NREQ) || gray_o !== CBITS'(ph) || valid_o !== 1'b1 || done !== (ph == 1)) begin
               n_bad++;
               $display("FAIL rr burst %0d beat %0d: owner=%0d gray=%h done=%b expected owner=%0d gray=%0d",
                        b, ph, owner, gray_o, done, b % NREQ, ph);
            end
         end else if (busy !== 1'b0 || valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rr bubble %0d: busy=%b valid=%b expected 0", b, busy, valid_o);
         end
      end
      req = '0;
      drain();
   endtask

   task automatic test_zero_len();
      req = 4'b0100;
      len = with_len(len, 2, 0);
      tick();
      req = '0;
      n_cmp++;
      if (grant !== 4'b0100 || busy !== 1'b1 || done !== 1'b1 || valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL zero_len: grant=%b busy=%b done=%b valid=%b expected 0100 1 1 0",
                  grant, busy, done, valid_o);
      end
      tick();
      n_cmp++;
      if (act_vec() !== '0) begin
         n_bad++;
         $display("FAIL zero_len idle: got %h expected 0", act_vec());
      end
      drain();
   endtask

   task automatic test_mid_change();
      logic [CBITS-1:0] g[4] = '{8'h00, 8'h01, 8'h03, 8'h02};
      int nbeat;
      nbeat = 0;
      req = 4'b0010;
      len = with_len(len, 1, 4);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 1) begin
            req = '0;
            len = with_len(len, 1, 9);
         end
         n_cmp++;
         if (act_vec() !== exp_o) begin
            n_bad++;
            $display("FAIL mid model cyc %0d: got %h expected %h", i, act_vec(), exp_o);
         end
         if (valid_o === 1'b1) begin
            n_cmp++;
            if (nbeat > 3 || gray_o !== g[nbeat & 3] || done !== (nbeat == 3)) begin
               n_bad++;
               $display("FAIL mid beat %0d: gray=%h done=%b", nbeat, gray_o, done);
            end
            nbeat++;
         end
      end
      n_cmp++;
      if (nbeat != 4) begin
         n_bad++;
         $display("FAIL mid beat count: got %0d expected 4", nbeat);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      req = 4'b0001;
      len = with_len(len, 0, 200);
      for (int i = 0; i < 50; i++) begin
         tick();
         if (i == 0) req = '0;
      end
      n_cmp++;
      if (gray_o !== CBITS'(49 ^ (49 >> 1)) || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid beat 49: gray=%h busy=%b", gray_o, busy);
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if (act_vec() !== '0) begin
         n_bad++;
         $display("FAIL rstmid abort: got %h expected 0", act_vec());
      end
      rst = 1'b1;
      req = 4'b1000;
      len = with_len(len, 3, 3);
      tick();
      req = '0;
      n_cmp++;
      if (grant !== 4'b1000 || owner !== 2'd3 || valid_o !== 1'b1 || act_vec() !== exp_o) begin
         n_bad++;
         $display("FAIL rstmid regrant: got %h expected %h", act_vec(), exp_o);
      end
      drain();
   endtask

   task automatic test_max_len();
      logic [CBITS-1:0] prev;
      int ndone;
      ndone = 0;
      prev  = '0;
      req = 4'b0001;
      len = with_len(len, 0, 255);
      for (int i = 0; i < 255; i++) begin
         tick();
         if (i == 0) req = '0;
         n_cmp++;
         if (act_vec() !== exp_o) begin
            n_bad++;
            $display("FAIL max model beat %0d: got %h expected %h", i, act_vec(), exp_o);
         end
         if (i > 0) begin
            n_cmp++;
            if ($countones(prev ^ gray_o) != 1) begin
               n_bad++;
               $display("FAIL max hamming beat %0d: prev=%h cur=%h", i, prev, gray_o);
            end
         end
         if (done === 1'b1) ndone++;
         prev = gray_o;
      end
      n_cmp++;
      if (gray_o !== 8'h81 || done !== 1'b1 || ndone != 1) begin
         n_bad++;
         $display("FAIL max last: gray=%h done=%b ndone=%0d expected 81 1 1", gray_o, done, ndone);
      end
      tick();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL max end: busy=%b expected 0", busy);
      end
      drain();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
         if ($urandom_range(0, 5) == 0) begin
            for (int i = 0; i < NREQ; i++) begin
               len = with_len(len, i, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40))
                                                                    : int'($urandom_range(0, 4)));
            end
         end
         rst = ($urandom_range(0, 299) != 0);
         tick();
         n_cmp++;
         if (act_vec() !== exp_o) begin
            n_bad++;
            $display("FAIL random model cyc %0d: got %h expected %h", c, act_vec(), exp_o);
         end
         n_cmp++;
         if (!$onehot0(grant) || busy !== (|grant) || (valid_o && !busy) || (done && !busy)) begin
            n_bad++;
            $display("FAIL random invariant cyc %0d: grant=%b busy=%b valid=%b done=%b",
                     c, grant, busy, valid_o, done);
         end
      end
      rst = 1'b1;
      req = '0;
      drain();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_zero_len();
      test_mid_change();
      test_reset_mid();
      test_max_len();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
